// File: rtl/text_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : text_frame_sequencer
// Brief    : Walks the vertical text pixel generator through one full frame.
//            Flips toggle_restart / toggle_next, waits out the generator read
//            latency, samples cur_pixels and offers each byte on a
//            valid/ready stream toward the frame writer.
// Revision : 1.0  initial release
// ============================================================================
module text_frame_sequencer #(
    parameter int FRAME_BYTES = 1024,
    parameter int SETTLE      = 4,
    parameter int CNT_SZ      = $clog2(FRAME_BYTES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              repeat_en,
    input  logic              abort,
    output logic              toggle_restart,
    output logic              toggle_next,
    input  logic [7:0]        gen_pixels,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [CNT_SZ-1:0] out_index,
    output logic              busy,
    output logic              frame_done
);

    // Settle counter runs 0..SETTLE-1; keep at least one bit for tiny SETTLE.
    localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SETTLE_W-1:0] c_SETTLE_LAST = SETTLE_W'(SETTLE - 1);
    localparam logic [CNT_SZ-1:0]   c_LAST_IDX    = CNT_SZ'(FRAME_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_PRESENT = 3'd2,
        S_NEXT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                state_q;
    logic [SETTLE_W-1:0]   settle_cnt_q;
    logic [CNT_SZ-1:0]     index_q;
    logic [7:0]            data_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  tog_restart_q;
    logic                  tog_next_q;

    // Combinational view of the handshake and of the frame's final byte.
    logic w_handshake;
    logic w_at_last;
    assign w_handshake = valid_q & out_ready;
    assign w_at_last   = (index_q == c_LAST_IDX);

    // Frame sequencing FSM; every output is a register so the stream is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            settle_cnt_q  <= '0;
            index_q       <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tog_restart_q <= 1'b0;
            tog_next_q    <= 1'b0;
        end else begin
            // frame_done is a single-cycle pulse; only PRESENT re-arms it.
            done_q <= 1'b0;

            if (abort && (state_q != S_IDLE)) begin
                // Abort beats any same-cycle handshake: the byte is not taken.
                // Toggles are left alone; the next start re-synchronises the generator.
                state_q      <= S_IDLE;
                settle_cnt_q <= '0;
                valid_q      <= 1'b0;
                last_q       <= 1'b0;
                busy_q       <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            tog_restart_q <= ~tog_restart_q;
                            index_q       <= '0;
                            settle_cnt_q  <= '0;
                            busy_q        <= 1'b1;
                            state_q       <= S_WAIT;
                        end
                    end

                    S_WAIT: begin
                        // Also re-raises busy after the one-cycle dip of a repeated frame.
                        busy_q <= 1'b1;
                        if (settle_cnt_q == c_SETTLE_LAST) begin
                            settle_cnt_q <= '0;
                            data_q       <= gen_pixels;
                            valid_q      <= 1'b1;
                            last_q       <= w_at_last;
                            state_q      <= S_PRESENT;
                        end else begin
                            settle_cnt_q <= settle_cnt_q + 1'b1;
                        end
                    end

                    S_PRESENT: begin
                        if (w_handshake) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            if (w_at_last) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                index_q <= index_q + 1'b1;
                                state_q <= S_NEXT;
                            end
                        end
                    end

                    S_NEXT: begin
                        // Separate cycle for the advance edge keeps bytes from running back-to-back.
                        tog_next_q   <= ~tog_next_q;
                        settle_cnt_q <= '0;
                        state_q      <= S_WAIT;
                    end

                    S_DONE: begin
                        busy_q <= 1'b0;
                        if (repeat_en) begin
                            tog_restart_q <= ~tog_restart_q;
                            index_q       <= '0;
                            settle_cnt_q  <= '0;
                            state_q       <= S_WAIT;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end

                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign toggle_restart = tog_restart_q;
    assign toggle_next    = tog_next_q;
    assign out_data       = data_q;
    assign out_valid      = valid_q;
    assign out_last       = last_q;
    assign out_index      = index_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;

endmodule
`default_nettype wire
